// File: rtl/hazard_ctl_pkg.sv
// Shared types and encodings for the WISC pipeline hazard/control unit.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package hazard_ctl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic       valid;
    logic [2:0] rx;
    logic       rx_used;
    logic [2:0] ry;
    logic       ry_used;
    logic [2:0] ro;
    logic       wen;
    logic       load;
    logic       halt;
  } slot_t;

  // True when the slot produces a register that the ID instruction reads.
  // r0 is an ordinary register, so no zero-register exemption.
  function automatic logic slot_hazard(input slot_t s, input logic [2:0] rx,
                                       input logic rx_used, input logic [2:0] ry,
                                       input logic ry_used);
    return s.valid & s.wen & ((rx_used & (rx == s.ro)) | (ry_used & (ry == s.ro)));
  endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// Bundle between the ID/EX datapath and the hazard/control unit.
// Latency: n/a (wires only).
// Backpressure: stall/fetch_hold hold the front end; no credit scheme.
interface hazard_ctl_if;
  logic       id_valid;
  logic [2:0] id_rX;
  logic       id_rX_used;
  logic [2:0] id_rY;
  logic       id_rY_used;
  logic [2:0] id_rO;
  logic       id_wen;
  logic       id_load;
  logic       id_halt;
  logic       ex_redirect;
  logic       stall;
  logic       flush_ifid;
  logic       idex_wen;
  logic       idex_bubble;
  logic       fetch_hold;
  logic [1:0] fwd_x_sel;
  logic [1:0] fwd_y_sel;
  logic       halted;

  // Pipeline side: drives ID decode fields, consumes control.
  modport master (
    output id_valid, id_rX, id_rX_used, id_rY, id_rY_used, id_rO,
           id_wen, id_load, id_halt, ex_redirect,
    input  stall, flush_ifid, idex_wen, idex_bubble, fetch_hold,
           fwd_x_sel, fwd_y_sel, halted
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rX, id_rX_used, id_rY, id_rY_used, id_rO,
           id_wen, id_load, id_halt, ex_redirect,
    output stall, flush_ifid, idex_wen, idex_bubble, fetch_hold,
           fwd_x_sel, fwd_y_sel, halted
  );
endinterface

// File: rtl/hazard_ctl_slot.sv
// Shadow pipeline slot: one registered in-flight instruction record.
// Latency: 1 cycle d->q.
// Backpressure: none; captures every edge, cleared asynchronously by rst.
module hazard_slot
  import hazard_ctl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  slot_t d,
  output slot_t q
);

  // Record register; reset leaves the slot empty (valid=0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/hazard_ctl.sv
// Hazard/control unit: ID issue decision, IF/ID flush, EX forwarding, halt drain.
// Latency: control outputs combinational from ID inputs and shadow slots; halted registered.
// Backpressure: stall/fetch_hold freeze PC and IF/ID; ID/EX always written, bubbled when needed.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter bit FWD = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctl_if.slave  hc
);

  slot_t  id_rec, ex_d, ex_q, mem_q, wb_q;
  state_t state;
  logic   halted_q;
  logic   hz_ex, hz_mem, raw_stall, issue;

  // ID fields packed as the record that enters EX on issue.
  always_comb begin
    id_rec         = '0;
    id_rec.valid   = hc.id_valid;
    id_rec.rx      = hc.id_rX;
    id_rec.rx_used = hc.id_rX_used;
    id_rec.ry      = hc.id_rY;
    id_rec.ry_used = hc.id_rY_used;
    id_rec.ro      = hc.id_rO;
    id_rec.wen     = hc.id_wen;
    id_rec.load    = hc.id_load;
    id_rec.halt    = hc.id_halt;
  end

  // A non-issued cycle puts a fully zeroed record into EX, so a bubble
  // never matches anything in the forwarding compare.
  assign ex_d = issue ? id_rec : '0;

  hazard_slot u_ex  (.clk(clk), .rst(rst), .d(ex_d),  .q(ex_q));
  hazard_slot u_mem (.clk(clk), .rst(rst), .d(ex_q),  .q(mem_q));
  hazard_slot u_wb  (.clk(clk), .rst(rst), .d(mem_q), .q(wb_q));

  // Stall decision: with forwarding only a load in EX blocks; without it
  // any producer in EX or MEM blocks (WB writes through the regfile).
  always_comb begin
    hz_ex  = slot_hazard(ex_q,  hc.id_rX, hc.id_rX_used, hc.id_rY, hc.id_rY_used);
    hz_mem = slot_hazard(mem_q, hc.id_rX, hc.id_rX_used, hc.id_rY, hc.id_rY_used);
    if (FWD) raw_stall = hc.id_valid & hz_ex & ex_q.load;
    else     raw_stall = hc.id_valid & (hz_ex | hz_mem);
  end

  // Redirect outranks stall; outputs held at reset values while rst is high.
  always_comb begin
    issue          = ~rst & hc.id_valid & ~hc.ex_redirect & ~raw_stall & (state == RUN);
    hc.stall       = ~rst & ~hc.ex_redirect & raw_stall;
    hc.flush_ifid  = ~rst & hc.ex_redirect;
    hc.idex_wen    = 1'b1;
    hc.idex_bubble = ~issue;
    hc.fetch_hold  = hc.stall | (state != RUN);
    hc.halted      = halted_q;
  end

  // Forward selects for the instruction now in EX; MEM beats WB, and a
  // load in MEM has no data yet so it cannot forward.
  always_comb begin
    hc.fwd_x_sel = FWD_RF;
    hc.fwd_y_sel = FWD_RF;
    if (FWD) begin
      if (mem_q.valid & mem_q.wen & ~mem_q.load & ex_q.rx_used & (ex_q.rx == mem_q.ro))
        hc.fwd_x_sel = FWD_MEM;
      else if (wb_q.valid & wb_q.wen & ex_q.rx_used & (ex_q.rx == wb_q.ro))
        hc.fwd_x_sel = FWD_WB;
      if (mem_q.valid & mem_q.wen & ~mem_q.load & ex_q.ry_used & (ex_q.ry == mem_q.ro))
        hc.fwd_y_sel = FWD_MEM;
      else if (wb_q.valid & wb_q.wen & ex_q.ry_used & (ex_q.ry == wb_q.ro))
        hc.fwd_y_sel = FWD_WB;
    end
  end

  // Halt sequencing: stop issuing at HALT, finish when it leaves WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN:     if (issue & hc.id_halt) state <= DRAIN;
        DRAIN:   if (wb_q.valid & wb_q.halt) begin
                   state    <= HALTED;
                   halted_q <= 1'b1;
                 end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
module tb_hazard_ctl;
  import hazard_ctl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctl_if a_if ();
  hazard_ctl_if b_if ();

  hazard_ctl #(.FWD(1'b1)) dut_a (.clk(clk), .rst(rst), .hc(a_if.slave));
  hazard_ctl #(.FWD(1'b0)) dut_b (.clk(clk), .rst(rst), .hc(b_if.slave));

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic slot_t instr(input logic [2:0] rx, input logic rxu,
                                  input logic [2:0] ry, input logic ryu,
                                  input logic [2:0] ro, input logic wen,
                                  input logic load, input logic halt);
    slot_t s;
    s = '{valid:1'b1, rx:rx, rx_used:rxu, ry:ry, ry_used:ryu,
          ro:ro, wen:wen, load:load, halt:halt};
    return s;
  endfunction

  task automatic drive_a(input slot_t s, input logic redir);
    a_if.id_valid = s.valid;  a_if.id_rX = s.rx;  a_if.id_rX_used = s.rx_used;
    a_if.id_rY = s.ry;  a_if.id_rY_used = s.ry_used;  a_if.id_rO = s.ro;
    a_if.id_wen = s.wen;  a_if.id_load = s.load;  a_if.id_halt = s.halt;
    a_if.ex_redirect = redir;
  endtask

  task automatic drive_b(input slot_t s, input logic redir);
    b_if.id_valid = s.valid;  b_if.id_rX = s.rx;  b_if.id_rX_used = s.rx_used;
    b_if.id_rY = s.ry;  b_if.id_rY_used = s.ry_used;  b_if.id_rO = s.ro;
    b_if.id_wen = s.wen;  b_if.id_load = s.load;  b_if.id_halt = s.halt;
    b_if.ex_redirect = redir;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  slot_t idle;
  slot_t ld_r3, add_r1, add_r3, sub_r4, ld_r5, use_r5, alu1, alu2, halt_i, use_r3;

  initial begin
    idle   = '0;
    ld_r3  = instr(3'd5, 1, 3'd0, 0, 3'd3, 1, 1, 0);
    add_r1 = instr(3'd3, 1, 3'd2, 1, 3'd1, 1, 0, 0);
    add_r3 = instr(3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0);
    sub_r4 = instr(3'd3, 1, 3'd3, 1, 3'd4, 1, 0, 0);
    ld_r5  = instr(3'd0, 1, 3'd0, 0, 3'd5, 1, 1, 0);
    use_r5 = instr(3'd5, 1, 3'd6, 1, 3'd7, 1, 0, 0);
    alu1   = instr(3'd6, 1, 3'd7, 1, 3'd1, 1, 0, 0);
    alu2   = instr(3'd6, 1, 3'd7, 1, 3'd2, 1, 0, 0);
    halt_i = instr(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
    use_r3 = instr(3'd3, 1, 3'd0, 0, 3'd4, 1, 0, 0);

    drive_a(idle, 0);
    drive_b(idle, 0);

    // Reset state
    #3;
    check_eq("rst_stall",   a_if.stall, 0);
    check_eq("rst_flush",   a_if.flush_ifid, 0);
    check_eq("rst_wen",     a_if.idex_wen, 1);
    check_eq("rst_bubble",  a_if.idex_bubble, 1);
    check_eq("rst_fhold",   a_if.fetch_hold, 0);
    check_eq("rst_fwdx",    a_if.fwd_x_sel, 0);
    check_eq("rst_fwdy",    a_if.fwd_y_sel, 0);
    check_eq("rst_halted",  a_if.halted, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // FWD=1 load-use: LD r3 then ADD r1,r3,r2
    drive_a(ld_r3, 0);  #1;
    check_eq("lu_ld_issue", a_if.idex_bubble, 0);
    tick();
    drive_a(add_r1, 0); #1;
    check_eq("lu_stall",    a_if.stall, 1);
    check_eq("lu_bubble",   a_if.idex_bubble, 1);
    check_eq("lu_fhold",    a_if.fetch_hold, 1);
    tick();
    #1;
    check_eq("lu_stall2",   a_if.stall, 0);
    check_eq("lu_issue2",   a_if.idex_bubble, 0);
    tick();
    drive_a(idle, 0);   #1;
    check_eq("lu_fwdx_wb",  a_if.fwd_x_sel, 2);
    check_eq("lu_fwdy_rf",  a_if.fwd_y_sel, 0);
    tick();

    // FWD=1 ALU-use: ADD r3 then SUB r4,r3,r3
    drive_a(add_r3, 0); #1;
    check_eq("au_stall0",   a_if.stall, 0);
    tick();
    drive_a(sub_r4, 0); #1;
    check_eq("au_stall1",   a_if.stall, 0);
    check_eq("au_issue",    a_if.idex_bubble, 0);
    tick();
    drive_a(idle, 0);   #1;
    check_eq("au_fwdx_mem", a_if.fwd_x_sel, 1);
    check_eq("au_fwdy_mem", a_if.fwd_y_sel, 1);
    tick();

    // Redirect beats a load-use stall
    drive_a(ld_r5, 0);  #1;
    tick();
    drive_a(use_r5, 1); #1;
    check_eq("rd_stall",    a_if.stall, 0);
    check_eq("rd_flush",    a_if.flush_ifid, 1);
    check_eq("rd_bubble",   a_if.idex_bubble, 1);
    tick();
    drive_a(idle, 0);   #1;
    check_eq("rd_flush_off", a_if.flush_ifid, 0);
    tick();

    // HALT behind two ALU ops
    drive_a(alu1, 0);   #1;
    tick();
    drive_a(alu2, 0);   #1;
    tick();
    drive_a(halt_i, 0); #1;
    check_eq("ht_issue",    a_if.idex_bubble, 0);
    check_eq("ht_fhold0",   a_if.fetch_hold, 0);
    tick();
    drive_a(alu1, 0);   #1;
    check_eq("ht_fhold1",   a_if.fetch_hold, 1);
    check_eq("ht_noissue1", a_if.idex_bubble, 1);
    check_eq("ht_halted1",  a_if.halted, 0);
    tick();
    check_eq("ht_halted2",  a_if.halted, 0);
    tick();
    check_eq("ht_halted3",  a_if.halted, 0);
    check_eq("ht_noissue3", a_if.idex_bubble, 1);
    tick();
    check_eq("ht_halted4",  a_if.halted, 1);
    check_eq("ht_fhold4",   a_if.fetch_hold, 1);
    check_eq("ht_noissue4", a_if.idex_bubble, 1);
    drive_a(idle, 0);

    // FWD=0: ADD r3 then use of r3 stalls two cycles
    drive_b(add_r3, 0); #1;
    tick();
    drive_b(use_r3, 0); #1;
    check_eq("nf_stall1",   b_if.stall, 1);
    tick();
    check_eq("nf_stall2",   b_if.stall, 1);
    check_eq("nf_bubble2",  b_if.idex_bubble, 1);
    tick();
    check_eq("nf_stall3",   b_if.stall, 0);
    check_eq("nf_issue3",   b_if.idex_bubble, 0);
    tick();
    drive_b(idle, 0);   #1;
    check_eq("nf_fwdx",     b_if.fwd_x_sel, 0);
    check_eq("nf_fwdy",     b_if.fwd_y_sel, 0);
    tick();

    // Async reset during DRAIN (FWD=0 so MEM producer is observable)
    drive_b(add_r3, 0); #1;
    tick();
    drive_b(halt_i, 0); #1;
    check_eq("dr_issue",    b_if.idex_bubble, 0);
    tick();
    drive_b(use_r3, 0); #1;
    check_eq("dr_stall",    b_if.stall, 1);
    check_eq("dr_fhold",    b_if.fetch_hold, 1);
    rst = 1'b1; #1;
    check_eq("ar_halted",   b_if.halted, 0);
    check_eq("ar_fhold",    b_if.fetch_hold, 0);
    check_eq("ar_bubble",   b_if.idex_bubble, 1);
    rst = 1'b0; #1;
    check_eq("ar_slots_clr", b_if.stall, 0);
    check_eq("ar_run_issue", b_if.idex_bubble, 0);
    check_eq("ar_fhold2",   b_if.fetch_hold, 0);
    check_eq("ar_a_halted", a_if.halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline hazard and control unit for the 5-stage WISC core.
- Decides every cycle whether the instruction in ID may enter the ID/EX pipeline register. Drives that register's write enable and its bubble (clear) control, plus the IF/ID hold and flush.
- Keeps a shadow scoreboard of in-flight destination registers (EX, MEM, WB), operand-forward selects for the EX stage, and the halt-drain sequence.

Parameters:
FWD, 1, 1 = EX/MEM and MEM/WB forwarding paths exist (stall only on load-use); 0 = no forwarding (stall while any producer sits in EX or MEM).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
id_valid  in  1  ID holds a real (non-bubble) instruction
id_rX  in  3  ID source X register
id_rX_used  in  1  ID instruction reads rX
id_rY  in  3  ID source Y register
id_rY_used  in  1  ID instruction reads rY
id_rO  in  3  ID destination register
id_wen  in  1  ID instruction writes rO
id_load  in  1  ID instruction is a memory load
id_halt  in  1  ID instruction is HALT
ex_redirect  in  1  branch/jump resolved taken in EX this cycle
stall  out  1  hold PC and IF/ID; ID/EX loads bubble
flush_ifid  out  1  IF/ID loads bubble next edge
idex_wen  out  1  ID/EX write enable (always 1; bubble via idex_bubble)
idex_bubble  out  1  ID/EX captures NOP (all controls zero)
fetch_hold  out  1  PC frozen (stall or draining/halted)
fwd_x_sel  out  2  EX operand X source: 0 regfile, 1 MEM-stage result, 2 WB result
fwd_y_sel  out  2  same for Y
halted  out  1  HALT has retired from WB

Behaviour:
- Shadow slots EX, MEM, WB. Each holds {valid, rX, rX_used, rY, rY_used, rO, wen, load, halt}. Reset: all valid=0.
- Every edge: WB<=MEM, MEM<=EX. EX<=ID fields when issue=1, else EX.valid<=0. No backend stalls exist.
- hazard(slot) = slot.valid & slot.wen & ((id_rX_used & id_rX==slot.rO) | (id_rY_used & id_rY==slot.rO)). r0 is a real register; no zero special case.
- FWD=1: raw_stall = id_valid & hazard(EX) & EX.load.
- FWD=0: raw_stall = id_valid & (hazard(EX) | hazard(MEM)). A WB producer needs no stall (regfile write-through).
- Priority:
  - ex_redirect=1: stall=0, flush_ifid=1, idex_bubble=1. Redirect beats stall and halt issue.
  - else raw_stall: stall=1, idex_bubble=1.
  - issue = id_valid & ~ex_redirect & ~raw_stall & state==RUN.
- idex_bubble also asserts whenever state!=RUN or id_valid=0.
- Forward selects are combinational from slot registers only:
  - fwd_x_sel=1 if FWD & MEM.valid & MEM.wen & ~MEM.load & EX.rX_used & EX.rX==MEM.rO.
  - else 2 if FWD & WB.valid & WB.wen & EX.rX_used & EX.rX==WB.rO.
  - else 0. MEM has priority over WB. Y is identical.
  - FWD=0: both selects tied 0.
- FSM:
  - RUN -> DRAIN when issue & id_halt.
  - DRAIN -> HALTED when WB.valid & WB.halt.
  - HALTED is terminal until rst.
- fetch_hold = stall | state!=RUN.
- In DRAIN, instructions older than the HALT still retire normally. ID is never issued after the HALT.
- halted=1 only in HALTED.
- Reset values: stall=0, flush_ifid=0, idex_wen=1, idex_bubble=1, fetch_hold=0, fwd_*=0, halted=0, state RUN.
- Reset mid-operation clears all slots and FSM immediately (asynchronous).

Decomposition:
- Shared package: FSM state encodings (RUN=0, DRAIN=1, HALTED=2) and fwd select constants (FWD_RF=0, FWD_MEM=1, FWD_WB=2).
- One sub-module, hazard_slot: shadow-slot record register built on the existing register primitive with async reset. Instantiated three times.

Test Plan:
- FWD=1; LD r3 then ADD r1,r3,r2 back-to-back -> exactly one cycle stall=1, idex_bubble=1. Next cycle fwd_x_sel=2 with ADD in EX.
- FWD=1; ADD r3 then SUB r4,r3,r3 -> stall never asserts. With SUB in EX, fwd_x_sel=fwd_y_sel=1.
- FWD=0; ADD r3 then use of r3 -> stall=1 for 2 cycles, then issue, fwd_*=0.
- ex_redirect=1 while ID has a load-use hazard -> stall=0, flush_ifid=1, idex_bubble=1 the same cycle.
- HALT issued behind 2 older ALU ops -> fetch_hold=1 from next cycle; halted rises exactly 3 cycles after HALT issue. No further issue.
- Assert rst during DRAIN -> halted=0, fetch_hold=0, all slots invalid on the same cycle, with no clock edge needed.
